// File: rtl/board_mem_arbiter.sv
// Arbitrates a CPU load/store port and a read-only display fetch port onto one single-port RAM.
// Define ARB_STARVE_GUARD_EN to let the display win after STARVE_LIMIT consecutive contested CPU grants.
module board_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  disp_req,
    input  logic [ADDR_WIDTH-1:0] disp_addr,
    output logic                  disp_valid,
    output logic [DATA_WIDTH-1:0] disp_rdata,
    output logic                  ram_wEn,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_dataIn,
    input  logic [DATA_WIDTH-1:0] ram_dataOut,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    logic   owner_disp;
    logic   owner_we;
    logic   any_req_c;
    logic   grant_disp_c;

    assign any_req_c = cpu_req | disp_req;

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_cnt;

    // Display wins when uncontested, or when the CPU has starved it STARVE_LIMIT times in a row.
    assign grant_disp_c = disp_req & (~cpu_req | (starve_cnt == STARVE_W'(STARVE_LIMIT)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (state == IDLE && any_req_c) begin
            if (grant_disp_c || !disp_req) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_W'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end
        end
    end
`else
    assign grant_disp_c = disp_req & ~cpu_req;
`endif

    // Fixed four-state access sequence; all outputs registered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner_disp <= 1'b0;
            owner_we   <= 1'b0;
            ram_wEn    <= 1'b0;
            ram_addr   <= '0;
            ram_dataIn <= '0;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= '0;
            disp_valid <= 1'b0;
            disp_rdata <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req_c) begin
                        owner_disp <= grant_disp_c;
                        owner_we   <= ~grant_disp_c & cpu_we;
                        ram_wEn    <= ~grant_disp_c & cpu_we;
                        ram_addr   <= grant_disp_c ? disp_addr : cpu_addr;
                        ram_dataIn <= grant_disp_c ? '0 : cpu_wdata;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_wEn <= 1'b0;
                    state   <= READ;
                end
                READ: begin
                    // RAM output is valid this cycle; a CPU write leaves cpu_rdata alone.
                    if (owner_disp) begin
                        disp_rdata <= ram_dataOut;
                        disp_valid <= 1'b1;
                    end else begin
                        if (!owner_we) begin
                            cpu_rdata <= ram_dataOut;
                        end
                        cpu_ack <= 1'b1;
                    end
                    state <= DONE;
                end
                DONE: begin
                    cpu_ack    <= 1'b0;
                    disp_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/board_mem_arbiter.md
BOARD_MEM_ARBITER -- requirements
Module: board_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, SHALL set the RAM word address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the RAM data width.
REQ-003 Parameter STARVE_LIMIT, default 4, SHALL set the consecutive-CPU-grant bound used by REQ-021.
REQ-004 Port clock, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, SHALL be an asynchronous, active-low reset.
REQ-006 Ports cpu_req, cpu_we (in, 1), cpu_addr (in, ADDR_WIDTH) and cpu_wdata (in, DATA_WIDTH) SHALL form the processor load/store request.
REQ-007 Ports cpu_ack (out, 1) and cpu_rdata (out, DATA_WIDTH) SHALL return the CPU completion pulse and the CPU read data.
REQ-008 Ports disp_req (in, 1) and disp_addr (in, ADDR_WIDTH) SHALL form the VGA board-cell fetch request, which is read-only.
REQ-009 Ports disp_valid (out, 1) and disp_rdata (out, DATA_WIDTH) SHALL return the display completion pulse and the display read data.
REQ-010 Ports ram_wEn (out, 1), ram_addr (out, ADDR_WIDTH), ram_dataIn (out, DATA_WIDTH) and ram_dataOut (in, DATA_WIDTH) SHALL connect to the single-port RAM, which has a 1-cycle registered read.
REQ-011 Port busy, output, 1, SHALL be high in every state except IDLE.

Function
REQ-012 The FSM SHALL have four states, IDLE, ISSUE, READ and DONE, and SHALL advance unconditionally from ISSUE to READ to DONE to IDLE.
REQ-013 In IDLE with any request present, the FSM SHALL pick a winner, register its address and data onto the ram_* outputs, latch the owner, and go to ISSUE; with no request present it SHALL stay in IDLE.
REQ-014 ram_wEn SHALL be high only in ISSUE, and only when the owner is the CPU and cpu_we was sampled as 1.
REQ-015 ram_addr and ram_dataIn SHALL hold constant from ISSUE through DONE.
REQ-016 In READ, the FSM SHALL capture ram_dataOut into the owner's rdata register on exit; a CPU write SHALL leave cpu_rdata unchanged.
REQ-017 The owner's ack or valid output SHALL be high for exactly the one DONE cycle.
REQ-018 Latency SHALL be fixed: a request seen in IDLE at cycle T gives RAM access at T+1, rdata at T+3, and the ack/valid pulse at T+3.
REQ-019 Handshake: a requester SHALL hold req, addr and data stable until its ack/valid; a req sampled in the IDLE following DONE SHALL be treated as a new request.
REQ-020 Default priority SHALL be CPU over display when both requests are present in IDLE.
REQ-021 A starve counter, sized for STARVE_LIMIT, SHALL increment on each CPU grant made while disp_req is high.
REQ-022 The starve counter SHALL clear on any display grant, and on any arbitration in which disp_req is low.
REQ-023 A request on the non-owning port during ISSUE, READ or DONE SHALL simply wait; it SHALL NOT be lost or reordered.
REQ-024 disp_rdata and cpu_rdata SHALL hold their last captured value between transactions.

Reset
REQ-025 Asserting reset SHALL immediately force IDLE, clear the owner and the starve counter, and drive ram_wEn, cpu_ack, disp_valid and busy to 0.
REQ-026 Asserting reset SHALL immediately drive ram_addr, ram_dataIn, cpu_rdata and disp_rdata to 0.
REQ-027 Reset during ISSUE SHALL abort the write with no ack; a reset mid-transaction SHALL drop that transaction and SHALL NOT produce a later pulse.
REQ-028 Leaving reset SHALL be synchronous to clock; the first arbitration SHALL occur in the first IDLE cycle after deassertion.

Configuration
REQ-029 Macro ARB_STARVE_GUARD_EN defined: when both requests are present in IDLE and the starve counter equals STARVE_LIMIT, the display SHALL win.
REQ-030 Macro ARB_STARVE_GUARD_EN undefined: arbitration SHALL be strict CPU priority, and the starve counter logic SHALL be absent.

Verification
REQ-031 CPU write then read: write 0x00000005 to 0x00A, then read 0x00A. Required: ram_wEn high for exactly 1 cycle, cpu_ack at T+3 each time, cpu_rdata = 0x00000005.
REQ-032 Display only: disp_req at addr 0x0C7 with RAM preloaded 0x00000003. Required: disp_valid pulses at T+3, disp_rdata = 0x00000003, ram_wEn stays 0.
REQ-033 Simultaneous requests in IDLE, CPU read 0x010 and display 0x020. Required: CPU is served first (ram_addr = 0x010); the display is served next, with ram_addr = 0x020 at the ISSUE following the CPU's DONE.
REQ-034 Starvation, guard enabled, STARVE_LIMIT = 4: CPU back-to-back requests with disp_req held high. Required: grants in order CPU, CPU, CPU, CPU, DISP, CPU. With the guard disabled, the display is never served while cpu_req stays high.
REQ-035 Reset during ISSUE of a CPU write to 0x005. Required: ram_wEn drops asynchronously, no cpu_ack occurs, busy = 0, and a later read of 0x005 returns the old data.
